// File: rtl/alu_sequencer.sv
// Multi-cycle ALU control sequencer: accepts a command, loads operands,
// steps the datapath for the needed count and holds the result.
module alu_sequencer #(
    parameter int WIDTH = 32,
    parameter int SHW = $clog2(WIDTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           op_valid,
    output logic           op_ready,
    input  logic [3:0]     OP,
    input  logic [SHW-1:0] SHAMT,
    output logic           res_valid,
    input  logic           res_ready,
    input  logic           abort,
    output logic           CISEL,
    output logic           LA,
    output logic           LR,
    output logic [1:0]     BSEL,
    output logic [1:0]     OSEL,
    output logic [1:0]     LOP,
    output logic           acc_load,
    output logic           step_en,
    output logic           err,
    output logic           busy
);

    localparam int CW = SHW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    typedef struct packed {
        logic       cisel;
        logic       la;
        logic       lr;
        logic [1:0] bsel;
        logic [1:0] osel;
        logic [1:0] lop;
    } ctl_t;

    function automatic ctl_t decode(input logic [3:0] op);
        ctl_t c;
        c = '0;
        unique case (op)
            4'd1: begin
                c.bsel  = 2'b01;
                c.cisel = 1'b1;
            end
            4'd2: begin
                c.la   = 1'b1;
                c.osel = 2'b01;
            end
            4'd3: begin
                c.lr   = 1'b1;
                c.osel = 2'b01;
            end
            4'd4: c.osel = 2'b01;
            4'd5: begin
                c.osel = 2'b10;
                c.lop  = 2'b01;
            end
            4'd6: c.osel = 2'b10;
            4'd7: begin
                c.osel = 2'b10;
                c.lop  = 2'b10;
            end
            4'd8: c.osel = 2'b11;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [CW-1:0] steps(input logic [3:0] op,
                                            input logic [SHW-1:0] sh);
        logic [CW-1:0] n;
        unique case (op)
            4'd2, 4'd3, 4'd4: n = {1'b0, sh};
            4'd8:             n = CW'(WIDTH);
            default:          n = CW'(1);
        endcase
        return n;
    endfunction

    state_t         state;
    logic [3:0]     op_r;
    logic [SHW-1:0] shamt_r;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  load_cnt;
    logic           rdy_q;
    logic           ld_q;
    logic           st_q;
    logic           rv_q;
    logic           err_q;
    ctl_t           ctl;

    assign load_cnt = steps(op_r, shamt_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_r    <= '0;
            shamt_r <= '0;
            cnt     <= '0;
            rdy_q   <= 1'b0;
            ld_q    <= 1'b0;
            st_q    <= 1'b0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else if (state != IDLE && abort) begin
            state <= IDLE;
            cnt   <= '0;
            rdy_q <= 1'b1;
            ld_q  <= 1'b0;
            st_q  <= 1'b0;
            rv_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ld_q <= 1'b0;
            st_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (op_valid && rdy_q) begin
                        op_r    <= OP;
                        shamt_r <= SHAMT;
                        rdy_q   <= 1'b0;
                        if (OP <= 4'd8) begin
                            state <= LOAD;
                            ld_q  <= 1'b1;
                        end else begin
                            state <= DONE;
                            rv_q  <= 1'b1;
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    cnt <= load_cnt;
                    if (load_cnt == '0) begin
                        state <= DONE;
                        rv_q  <= 1'b1;
                    end else begin
                        state <= RUN;
                        st_q  <= 1'b1;
                    end
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                        rv_q  <= 1'b1;
                    end else begin
                        st_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                        rv_q  <= 1'b0;
                        err_q <= 1'b0;
                        rdy_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // abort squashes strobes and the result in the very cycle it is seen
    assign acc_load  = ld_q & ~abort;
    assign step_en   = st_q & ~abort;
    assign res_valid = rv_q & ~abort;
    assign op_ready  = rdy_q;
    assign err       = err_q;
    assign busy      = (state != IDLE);

    assign ctl = (state == IDLE) ? '0 : decode(op_r);
    assign CISEL = ctl.cisel;
    assign LA    = ctl.la;
    assign LR    = ctl.lr;
    assign BSEL  = ctl.bsel;
    assign OSEL  = ctl.osel;
    assign LOP   = ctl.lop;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: vector table, hand sequences for abort/reset,
// and random commands against a rule-based reference model.
module tb_alu_sequencer;

    localparam int W = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          op_valid = 1'b0;
    logic          res_ready = 1'b0;
    logic          abort = 1'b0;
    logic [3:0]    op = '0;
    logic [SW-1:0] shamt = '0;
    logic          op_ready, res_valid, CISEL, LA, LR;
    logic [1:0]    BSEL, OSEL, LOP;
    logic          acc_load, step_en, err, busy;
    logic [8:0]    ctl_now;

    alu_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready),
        .OP(op), .SHAMT(shamt),
        .res_valid(res_valid), .res_ready(res_ready),
        .abort(abort),
        .CISEL(CISEL), .LA(LA), .LR(LR),
        .BSEL(BSEL), .OSEL(OSEL), .LOP(LOP),
        .acc_load(acc_load), .step_en(step_en),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    assign ctl_now = {CISEL, LA, LR, BSEL, OSEL, LOP};

    typedef struct {
        logic [3:0]    op;
        logic [SW-1:0] sh;
        int            lat;
        int            steps;
        logic [8:0]    ctl;
        logic          er;
        int            hold;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] o, input logic [SW-1:0] s,
                                input int lat, input int st,
                                input logic [8:0] c, input logic e,
                                input int h);
        vec_t v;
        v.op = o; v.sh = s; v.lat = lat; v.steps = st;
        v.ctl = c; v.er = e; v.hold = h;
        return v;
    endfunction

    // Reference: steps, latency and control word straight from the opcode rules
    function automatic vec_t model(input logic [3:0] o, input logic [SW-1:0] s,
                                   input int h);
        vec_t v;
        int n;
        logic [1:0] osel, lop;
        v.op = o; v.sh = s; v.hold = h;
        v.er = (o > 8);
        if (v.er) n = 0;
        else if (o >= 2 && o <= 4) n = int'(s);
        else if (o == 8) n = W;
        else n = 1;
        v.steps = n;
        v.lat = v.er ? 1 : (n == 0 ? 2 : n + 2);
        osel = (o == 8) ? 2'd3 : (o >= 2 && o <= 4) ? 2'd1 :
               (o >= 5 && o <= 7) ? 2'd2 : 2'd0;
        lop = (o == 5) ? 2'd1 : (o == 7) ? 2'd2 : 2'd0;
        v.ctl = {o == 1, o == 2, o == 3, (o == 1) ? 2'b01 : 2'b00, osel, lop};
        return v;
    endfunction

    // Entered and left just after a falling edge
    task automatic run(input vec_t v, input logic abort_acc);
        int first, n;
        logic seq_ok, ctl_ok, er_seen, exp_ld, exp_st;
        n = 0;
        while (op_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("ready op%0d", v.op), op_ready, 1);
        op_valid = 1'b1;
        op = v.op;
        shamt = v.sh;
        abort = abort_acc;
        res_ready = (v.hold == 0);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        abort = 1'b0;
        op = 4'($urandom);
        shamt = SW'($urandom);
        first = -1;
        seq_ok = 1'b1;
        ctl_ok = 1'b1;
        er_seen = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            exp_ld = !v.er && k == 1;
            exp_st = !v.er && k >= 2 && k <= v.steps + 1;
            if (acc_load !== exp_ld || step_en !== exp_st) seq_ok = 1'b0;
            if (ctl_now !== v.ctl || busy !== 1'b1 || op_ready !== 1'b0)
                ctl_ok = 1'b0;
            if (first >= 0 && res_valid !== 1'b1) seq_ok = 1'b0;
            if (res_valid === 1'b1) begin
                if (first < 0) begin
                    first = k;
                    er_seen = err;
                end
                if (err !== v.er) ctl_ok = 1'b0;
                if (k - first >= v.hold) begin
                    res_ready = 1'b1;
                    @(posedge clk);
                    #1 res_ready = 1'b0;
                    break;
                end
            end
        end
        chk($sformatf("latency op%0d", v.op), first, v.lat);
        chk($sformatf("strobes op%0d", v.op), seq_ok, 1);
        chk($sformatf("controls op%0d", v.op), ctl_ok, 1);
        chk($sformatf("err op%0d", v.op), er_seen, v.er);
        @(negedge clk);
        chk($sformatf("idle op%0d", v.op),
            {op_ready, busy, res_valid, ctl_now}, {3'b100, 9'd0});
    endtask

    vec_t tbl[13];
    int cnt_rv;

    initial begin
        tbl[0]  = mk(4'd0,  5'd7,  3,  1,  9'b0_0_0_00_00_00, 0, 0);
        tbl[1]  = mk(4'd1,  5'd0,  3,  1,  9'b1_0_0_01_00_00, 0, 0);
        tbl[2]  = mk(4'd2,  5'd3,  5,  3,  9'b0_1_0_00_01_00, 0, 0);
        tbl[3]  = mk(4'd3,  5'd5,  7,  5,  9'b0_0_1_00_01_00, 0, 0);
        tbl[4]  = mk(4'd3,  5'd0,  2,  0,  9'b0_0_1_00_01_00, 0, 0);
        tbl[5]  = mk(4'd4,  5'd31, 33, 31, 9'b0_0_0_00_01_00, 0, 2);
        tbl[6]  = mk(4'd4,  5'd1,  3,  1,  9'b0_0_0_00_01_00, 0, 0);
        tbl[7]  = mk(4'd5,  5'd9,  3,  1,  9'b0_0_0_00_10_01, 0, 0);
        tbl[8]  = mk(4'd6,  5'd2,  3,  1,  9'b0_0_0_00_10_00, 0, 0);
        tbl[9]  = mk(4'd7,  5'd4,  3,  1,  9'b0_0_0_00_10_10, 0, 1);
        tbl[10] = mk(4'd8,  5'd0,  34, 32, 9'b0_0_0_00_11_00, 0, 4);
        tbl[11] = mk(4'd10, 5'd3,  1,  0,  9'b0_0_0_00_00_00, 1, 0);
        tbl[12] = mk(4'd15, 5'd0,  1,  0,  9'b0_0_0_00_00_00, 1, 2);

        #3;
        chk("reset outs",
            {op_ready, res_valid, busy, err, acc_load, step_en, ctl_now}, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("ready before edge", op_ready, 0);
        @(negedge clk);
        chk("ready after edge", op_ready, 1);

        foreach (tbl[i]) run(tbl[i], 1'b0);

        // abort asserted while idle must not block the accept
        run(tbl[0], 1'b1);

        // abort in the middle of a long shift
        op_valid = 1'b1; op = 4'd4; shamt = 5'd20; res_ready = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("sll stepping", step_en, 1);
        abort = 1'b1;
        #1;
        chk("abort gates", {step_en, acc_load, res_valid}, 0);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort idle", {op_ready, busy, res_valid, step_en}, 4'b1000);
        run(tbl[0], 1'b0);

        // abort beats res_ready in DONE
        op_valid = 1'b1; op = 4'd7; res_ready = 1'b0;
        @(posedge clk);
        #1 op_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("xor done", {res_valid, LOP}, 3'b110);
        abort = 1'b1;
        res_ready = 1'b1;
        #1 chk("abort vs ready", res_valid, 0);
        @(posedge clk);
        #1 begin abort = 1'b0; res_ready = 1'b0; end
        @(negedge clk);
        chk("abort done idle", {op_ready, busy, res_valid}, 3'b100);

        // reset in the middle of a multiply
        op_valid = 1'b1; op = 4'd8; res_ready = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mul running", {step_en, OSEL}, 3'b111);
        #2 rst_n = 1'b0;
        #1 chk("async reset outs",
               {op_ready, res_valid, busy, err, acc_load, step_en, ctl_now}, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("ready pre edge", op_ready, 0);
        @(negedge clk);
        chk("ready post edge", op_ready, 1);
        cnt_rv = 0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || busy !== 1'b0) cnt_rv++;
        end
        chk("no stale result", cnt_rv, 0);

        for (int i = 0; i < 30; i++) begin
            run(model(4'($urandom_range(0, 15)), SW'($urandom_range(0, 31)),
                      int'($urandom_range(0, 3))), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
